kj_sync_tx: RTL and testbench

KJ_SYNC_TX -- requirements
Module: kj_sync_tx

---
 rtl/kj_sync_tx.sv | 183 ++++++++++++++++++
 tb/tb_kj_sync_tx.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/kj_sync_tx.sv
// rtl/kj_sync_tx.sv - K/J line-state transmitter: SYNC, NRZI data with bit stuffing, EOP
module kj_sync_tx #(
   parameter int CLK_PER_SYM = 1,
   parameter int STUFF_EN    = 1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       k,
   output logic       j,
   output logic       tx_en,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP} state_t;

   state_t     state, state_n;
   logic [4:0] sym_cnt, sym_cnt_n;
   logic [2:0] idx, idx_n;
   logic [7:0] shreg, shreg_n;
   logic [7:0] hold, hold_n;
   logic       hold_full, hold_full_n;
   logic [2:0] ones, ones_n;
   logic       k_n, j_n, tx_en_n, tx_ready_n, done_n;
   logic       sym_last, accept;
   logic       do_load, do_emit, emit_bit;

   assign sym_last = (sym_cnt == 5'(CLK_PER_SYM - 1));
   assign accept   = tx_valid && tx_ready;
   assign busy     = (state != IDLE);

   // Next-state, next-symbol and buffer/shift-register bookkeeping; line outputs are
   // computed one cycle ahead so they come straight out of flops.
   always_comb begin
      state_n     = state;
      sym_cnt_n   = sym_cnt;
      idx_n       = idx;
      shreg_n     = shreg;
      hold_n      = hold;
      hold_full_n = hold_full;
      ones_n      = ones;
      k_n         = k;
      j_n         = j;
      tx_en_n     = tx_en;
      done_n      = 1'b0;
      do_load     = 1'b0;
      do_emit     = 1'b0;
      emit_bit    = 1'b0;

      if (accept) begin
         hold_n      = tx_data;
         hold_full_n = 1'b1;
      end

      if (state != IDLE) begin
         sym_cnt_n = sym_last ? 5'd0 : sym_cnt + 5'd1;
      end

      case (state)
         IDLE: begin
            k_n     = 1'b0;
            j_n     = 1'b1;
            tx_en_n = 1'b0;
            // A byte that slipped in on the last data cycle of a packet starts a new one here.
            if (accept || hold_full) begin
               state_n   = SYNC;
               sym_cnt_n = 5'd0;
               idx_n     = 3'd0;
               ones_n    = 3'd0;
               k_n       = 1'b1;
               j_n       = 1'b0;
               tx_en_n   = 1'b1;
            end
         end
         SYNC: begin
            if (sym_last) begin
               if (idx == 3'd7) begin
                  do_load = 1'b1;
               end else begin
                  // Symbol idx+1 is K when even, and the final symbol is K as well.
                  idx_n = idx + 3'd1;
                  k_n   = idx[0] || (idx == 3'd6);
                  j_n   = !k_n;
               end
            end
         end
         DATA, STUFF: begin
            if (sym_last) begin
               if (state == DATA && STUFF_EN != 0 && ones == 3'd6) begin
                  state_n = STUFF;
                  k_n     = !k;
                  j_n     = k;
                  ones_n  = 3'd0;
               end else if (idx != 3'd7) begin
                  state_n  = DATA;
                  idx_n    = idx + 3'd1;
                  shreg_n  = {1'b0, shreg[7:1]};
                  do_emit  = 1'b1;
                  emit_bit = shreg[1];
               end else if (hold_full) begin
                  do_load = 1'b1;
               end else begin
                  state_n = EOP;
                  idx_n   = 3'd0;
                  k_n     = 1'b0;
                  j_n     = 1'b0;
               end
            end
         end
         EOP: begin
            if (sym_last) begin
               if (idx == 3'd2) begin
                  state_n = IDLE;
                  idx_n   = 3'd0;
                  k_n     = 1'b0;
                  j_n     = 1'b1;
                  tx_en_n = 1'b0;
                  done_n  = 1'b1;
               end else begin
                  idx_n = idx + 3'd1;
                  k_n   = 1'b0;
                  j_n   = (idx == 3'd1);
               end
            end
         end
         default: state_n = IDLE;
      endcase

      // Buffer-to-shift-register move; the first bit of the new byte goes out immediately.
      if (do_load) begin
         state_n     = DATA;
         idx_n       = 3'd0;
         shreg_n     = hold;
         hold_full_n = 1'b0;
         do_emit     = 1'b1;
         emit_bit    = hold[0];
      end

      // NRZI: a 0 toggles the current line level, a 1 holds it.
      if (do_emit) begin
         k_n    = emit_bit ? k : !k;
         j_n    = !k_n;
         ones_n = emit_bit ? ones + 3'd1 : 3'd0;
      end

      tx_ready_n = !hold_full_n && (state_n != EOP);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state     <= IDLE;
         sym_cnt   <= 5'd0;
         idx       <= 3'd0;
         shreg     <= 8'd0;
         hold      <= 8'd0;
         hold_full <= 1'b0;
         ones      <= 3'd0;
         k         <= 1'b0;
         j         <= 1'b1;
         tx_en     <= 1'b0;
         tx_ready  <= 1'b1;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         sym_cnt   <= sym_cnt_n;
         idx       <= idx_n;
         shreg     <= shreg_n;
         hold      <= hold_n;
         hold_full <= hold_full_n;
         ones      <= ones_n;
         k         <= k_n;
         j         <= j_n;
         tx_en     <= tx_en_n;
         tx_ready  <= tx_ready_n;
         done      <= done_n;
      end
   end

endmodule

// File: tb/tb_kj_sync_tx.sv
// tb/tb_kj_sync_tx.sv - directed self-checking bench for kj_sync_tx
module tb_kj_sync_tx;

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] tx_data;
   logic       tx_valid;

   logic a_ready, a_k, a_j, a_en, a_busy, a_done;
   logic n_ready, n_k, n_j, n_en, n_busy, n_done;
   logic f_ready, f_k, f_j, f_en, f_busy, f_done;

   always #5 CLK = ~CLK;

   kj_sync_tx #(.CLK_PER_SYM(1), .STUFF_EN(1)) dut_a (
      .CLK(CLK), .RST(RST), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(a_ready),
      .k(a_k), .j(a_j), .tx_en(a_en), .busy(a_busy), .done(a_done));

   kj_sync_tx #(.CLK_PER_SYM(1), .STUFF_EN(0)) dut_n (
      .CLK(CLK), .RST(RST), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(n_ready),
      .k(n_k), .j(n_j), .tx_en(n_en), .busy(n_busy), .done(n_done));

   kj_sync_tx #(.CLK_PER_SYM(4), .STUFF_EN(1)) dut_f (
      .CLK(CLK), .RST(RST), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(f_ready),
      .k(f_k), .j(f_j), .tx_en(f_en), .busy(f_busy), .done(f_done));

   int n_chk  = 0;
   int n_fail = 0;

   string       s_a, s_n, s_f;
   int          en_a, en_n, en_f;
   int          done_a, done_n, done_f, dcnt_a;
   int          busy_a, hold_err_f, first_rdy;
   logic [31:0] rdy_a;
   bit          inject = 1'b0;
   logic [7:0]  inject_data = 8'h00;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic chk_s(input string tag, input string obs, input string exp);
      n_chk++;
      assert (obs == exp) else begin
         n_fail++;
         $error("FAIL %s: observed %s expected %s", tag, obs, exp);
      end
   endtask

   function automatic string sym(input logic kk, input logic jj);
      if (kk && !jj) return "K";
      if (!kk && jj) return "J";
      if (!kk && !jj) return "0";
      return "X";
   endfunction

   // Called at posedge+1 with tx_valid set; returns at posedge+1 of the first cycle after acceptance.
   task automatic send(input logic [7:0] d);
      tx_data  = d;
      tx_valid = 1'b1;
      @(posedge CLK);
      #1;
      tx_valid = 1'b0;
   endtask

   task automatic capture(input int n);
      string cur_f;
      s_a = ""; s_n = ""; s_f = ""; cur_f = "";
      en_a = 0; en_n = 0; en_f = 0;
      done_a = -1; done_n = -1; done_f = -1; dcnt_a = 0;
      busy_a = 0; hold_err_f = 0; first_rdy = -1; rdy_a = '0;
      for (int i = 0; i < n; i++) begin
         if (a_en) begin s_a = {s_a, sym(a_k, a_j)}; en_a++; end
         if (n_en) begin s_n = {s_n, sym(n_k, n_j)}; en_n++; end
         if (a_busy) busy_a++;
         if (a_done) begin dcnt_a++; if (done_a < 0) done_a = i; end
         if (n_done && done_n < 0) done_n = i;
         if (f_done && done_f < 0) done_f = i;
         if (f_en) en_f++;
         if (i % 4 == 0) begin
            cur_f = sym(f_k, f_j);
            if (f_en) s_f = {s_f, cur_f};
         end else if (f_en && sym(f_k, f_j) != cur_f) begin
            hold_err_f++;
         end
         if (i < 32) rdy_a[i] = a_ready;
         if (a_ready && first_rdy < 0) begin
            first_rdy = i;
            if (inject) begin
               tx_valid = 1'b1;
               tx_data  = inject_data;
            end
         end else begin
            tx_valid = 1'b0;
         end
         @(posedge CLK);
         #1;
      end
      tx_valid = 1'b0;
   endtask

   initial begin
      RST      = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b1;

      chk("reset_a", int'({a_k, a_j, a_en, a_ready, a_busy, a_done}), 6'b010100);
      chk("reset_f", int'({f_k, f_j, f_en, f_ready, f_busy, f_done}), 6'b010100);
      repeat (3) @(posedge CLK);
      #1;
      chk("idle_stable_a", int'({a_k, a_j, a_en, a_ready, a_busy, a_done}), 6'b010100);
      chk("idle_stable_n", int'({n_k, n_j, n_en, n_ready, n_busy, n_done}), 6'b010100);

      send(8'h00);
      capture(80);
      chk_s("seq_00", s_a, "KJKJKJKKJKJKJKJK00J");
      chk("txen_00", en_a, 19);
      chk("done_at_00", done_a, 19);
      chk("done_cnt_00", dcnt_a, 1);
      chk("busy_00", busy_a, 19);
      chk("rdy_first_00", first_rdy, 8);
      chk("rdy_vec_00", int'(rdy_a[19:0]), 20'h8FF00);
      chk_s("seq_00_cps4", s_f, "KJKJKJKKJKJKJKJK00J");
      chk("txen_00_cps4", en_f, 76);
      chk("done_at_00_cps4", done_f, 76);
      chk("hold_00_cps4", hold_err_f, 0);

      send(8'hFF);
      capture(90);
      chk_s("seq_ff_stuff", s_a, "KJKJKJKKKKKKKKJJJ00J");
      chk("txen_ff_stuff", en_a, 20);
      chk("done_at_ff_stuff", done_a, 20);
      chk_s("seq_ff_nostuff", s_n, "KJKJKJKKKKKKKKKK00J");
      chk("txen_ff_nostuff", en_n, 19);

      send(8'hFC);
      capture(90);
      chk_s("seq_fc_stuff_last", s_a, "KJKJKJKKJKKKKKKKJ00J");
      chk("done_at_fc", done_a, 20);
      chk_s("seq_fc_nostuff", s_n, "KJKJKJKKJKKKKKKK00J");
      chk("done_at_fc_nostuff", done_n, 19);

      inject      = 1'b1;
      inject_data = 8'h01;
      send(8'h80);
      capture(100);
      inject = 1'b0;
      chk_s("seq_80_01", s_a, "KJKJKJKKJKJKJKJJJKJKJKJK00J");
      chk("txen_80_01", en_a, 27);
      chk("done_at_80_01", done_a, 27);
      chk("done_cnt_80_01", dcnt_a, 1);
      chk("rdy_first_80_01", first_rdy, 8);
      chk("rdy_vec_80_01", int'(rdy_a[27:0]), 28'h8FF0100);
      chk_s("seq_80_cps4_ignored", s_f, "KJKJKJKKJKJKJKJJ00J");

      send(8'h00);
      repeat (11) @(posedge CLK);
      #1;
      chk("mid_active", int'(a_en), 1);
      chk_s("mid_sym", sym(a_k, a_j), "K");
      RST = 1'b0;
      @(posedge CLK);
      #1;
      chk("mid_reset_a", int'({a_k, a_j, a_en, a_ready, a_busy, a_done}), 6'b010100);
      RST = 1'b1;
      capture(30);
      chk("abort_txen", en_a, 0);
      chk("abort_done", dcnt_a, 0);

      send(8'h00);
      capture(80);
      chk_s("seq_after_abort", s_a, "KJKJKJKKJKJKJKJK00J");
      chk("done_at_after_abort", done_a, 19);
      chk("txen_after_abort_cps4", en_f, 76);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
